// File: rtl/io_input_conditioner.sv
// io_input_conditioner
//
// Synchronises, debounces and edge-detects the raw board inputs before they
// reach the memory-mapped IO decoder.
//
// Ports:
//   clk            system clock, all state updates on its rising edge
//   rst            synchronous active-high reset
//   buttonL_raw    raw asynchronous left button
//   buttonR_raw    raw asynchronous right button
//   switch_raw     raw asynchronous 16-bit switch bank
//   buttonL        debounced left button level
//   buttonR        debounced right button level
//   buttonL_pulse  one-cycle pulse on each debounced 0->1 of buttonL
//   buttonR_pulse  one-cycle pulse on each debounced 0->1 of buttonR
//   switch         debounced switch vector
//   switch_changed one-cycle pulse in the first cycle switch shows a new value
module io_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        buttonL_raw,
    input  logic        buttonR_raw,
    input  logic [15:0] switch_raw,
    output logic        buttonL,
    output logic        buttonR,
    output logic        buttonL_pulse,
    output logic        buttonR_pulse,
    output logic [15:0] switch,
    output logic        switch_changed
);

    localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    // Two-flop synchroniser for all 18 raw bits; only sync2_q feeds logic.
    logic [17:0] sync1_q;
    logic [17:0] sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {switch_raw, buttonR_raw, buttonL_raw};
            sync2_q <= sync1_q;
        end
    end

    logic [1:0]  btn_s2;
    logic [15:0] sw_s2;

    assign btn_s2 = sync2_q[1:0];
    assign sw_s2  = sync2_q[17:2];

    // Button channels: index 0 = left, 1 = right.
    logic [1:0]           btn_stable_q;
    logic [1:0]           btn_level_q;
    logic [1:0]           btn_pulse_q;
    logic [CNT_WIDTH-1:0] btn_cnt_q [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_stable_q <= '0;
            btn_level_q  <= '0;
            btn_pulse_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                btn_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (btn_s2[i] == btn_stable_q[i]) begin
                    // Any return to the accepted value discards the count.
                    btn_cnt_q[i] <= '0;
                end else if (btn_cnt_q[i] == CntMax) begin
                    btn_stable_q[i] <= btn_s2[i];
                    btn_cnt_q[i]    <= '0;
                end else begin
                    btn_cnt_q[i] <= btn_cnt_q[i] + CntOne;
                end
            end
            // Output stage: the level and its rising-edge pulse appear together,
            // aligned with the switch bank's acceptance latency.
            btn_level_q <= btn_stable_q;
            btn_pulse_q <= btn_stable_q & ~btn_level_q;
        end
    end

    // Switch bank: one shared debouncer; any bit change restarts the count.
    logic [15:0]          sw_stable_q;
    logic [15:0]          sw_cand_q;
    logic [CNT_WIDTH-1:0] sw_cnt_q;
    logic                 sw_changed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_stable_q  <= '0;
            sw_cand_q    <= '0;
            sw_cnt_q     <= '0;
            sw_changed_q <= 1'b0;
        end else begin
            sw_changed_q <= 1'b0;
            if (sw_s2 == sw_stable_q) begin
                sw_cnt_q <= '0;
            end else if (sw_s2 != sw_cand_q) begin
                sw_cand_q <= sw_s2;
                sw_cnt_q  <= '0;
            end else if (sw_cnt_q == CntMax) begin
                sw_stable_q  <= sw_cand_q;
                sw_cnt_q     <= '0;
                sw_changed_q <= 1'b1;
            end else begin
                sw_cnt_q <= sw_cnt_q + CntOne;
            end
        end
    end

    assign buttonL        = btn_level_q[0];
    assign buttonR        = btn_level_q[1];
    assign buttonL_pulse  = btn_pulse_q[0];
    assign buttonR_pulse  = btn_pulse_q[1];
    assign switch         = sw_stable_q;
    assign switch_changed = sw_changed_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
module tb_io_input_conditioner;

    logic        clk = 1'b0;
    logic        rst;
    logic        buttonL_raw;
    logic        buttonR_raw;
    logic [15:0] switch_raw;
    logic        buttonL;
    logic        buttonR;
    logic        buttonL_pulse;
    logic        buttonR_pulse;
    logic [15:0] switch;
    logic        switch_changed;

    int total = 0;
    int bad   = 0;

    io_input_conditioner #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .buttonL_raw   (buttonL_raw),
        .buttonR_raw   (buttonR_raw),
        .switch_raw    (switch_raw),
        .buttonL       (buttonL),
        .buttonR       (buttonR),
        .buttonL_pulse (buttonL_pulse),
        .buttonR_pulse (buttonR_pulse),
        .switch        (switch),
        .switch_changed(switch_changed)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle 1 time unit before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observed vector layout: {L, R, L_pulse, R_pulse, changed, switch[15:0]}.
    task automatic expect_all(input string tag, input logic bl, input logic br,
                              input logic blp, input logic brp, input logic swc,
                              input logic [15:0] sw);
        logic [20:0] obs;
        logic [20:0] exp;
        obs = {buttonL, buttonR, buttonL_pulse, buttonR_pulse, switch_changed, switch};
        exp = {bl, br, blp, brp, swc, sw};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1. Reset with all raws high, then release.
        rst         = 1'b1;
        buttonL_raw = 1'b1;
        buttonR_raw = 1'b1;
        switch_raw  = 16'hFFFF;
        tick();
        expect_all("rst_hold1", 0, 0, 0, 0, 0, 16'h0000);
        tick();
        expect_all("rst_hold2", 0, 0, 0, 0, 0, 16'h0000);
        rst = 1'b0;
        for (int e = 0; e < 6; e++) begin
            tick();
            expect_all("rst_latency", 0, 0, 0, 0, 0, 16'h0000);
        end
        tick();
        expect_all("rst_accept", 1, 1, 1, 1, 1, 16'hFFFF);
        tick();
        expect_all("rst_pulse_end", 1, 1, 0, 0, 0, 16'hFFFF);

        // Drop everything: buttons fall without pulses, switch change pulses.
        buttonL_raw = 1'b0;
        buttonR_raw = 1'b0;
        switch_raw  = 16'h0000;
        for (int e = 0; e < 6; e++) begin
            tick();
            expect_all("fall_latency", 1, 1, 0, 0, 0, 16'hFFFF);
        end
        tick();
        expect_all("fall_accept", 0, 0, 0, 0, 1, 16'h0000);
        tick();
        expect_all("fall_settled", 0, 0, 0, 0, 0, 16'h0000);

        // 2. Clean press and release of the left button.
        buttonL_raw = 1'b1;
        for (int e = 0; e < 6; e++) begin
            tick();
            expect_all("press_latency", 0, 0, 0, 0, 0, 16'h0000);
        end
        tick();
        expect_all("press_accept", 1, 0, 1, 0, 0, 16'h0000);
        for (int e = 0; e < 4; e++) begin
            tick();
            expect_all("press_hold", 1, 0, 0, 0, 0, 16'h0000);
        end
        buttonL_raw = 1'b0;
        for (int e = 0; e < 6; e++) begin
            tick();
            expect_all("release_latency", 1, 0, 0, 0, 0, 16'h0000);
        end
        tick();
        expect_all("release_accept", 0, 0, 0, 0, 0, 16'h0000);

        // 3. Bounce on the right button: 1,0,1,0 then held at 1.
        buttonR_raw = 1'b1;
        tick();
        expect_all("bounce_e0", 0, 0, 0, 0, 0, 16'h0000);
        buttonR_raw = 1'b0;
        tick();
        expect_all("bounce_e1", 0, 0, 0, 0, 0, 16'h0000);
        buttonR_raw = 1'b1;
        tick();
        expect_all("bounce_e2", 0, 0, 0, 0, 0, 16'h0000);
        buttonR_raw = 1'b0;
        tick();
        expect_all("bounce_e3", 0, 0, 0, 0, 0, 16'h0000);
        buttonR_raw = 1'b1;
        for (int e = 4; e < 10; e++) begin
            tick();
            expect_all("bounce_wait", 0, 0, 0, 0, 0, 16'h0000);
        end
        tick();
        expect_all("bounce_accept", 0, 1, 0, 1, 0, 16'h0000);
        for (int e = 0; e < 3; e++) begin
            tick();
            expect_all("bounce_hold", 0, 1, 0, 0, 0, 16'h0000);
        end

        // 4. Three-cycle glitch on the left button is rejected.
        buttonL_raw = 1'b1;
        tick();
        tick();
        tick();
        buttonL_raw = 1'b0;
        for (int e = 0; e < 10; e++) begin
            tick();
            expect_all("glitch", 0, 1, 0, 0, 0, 16'h0000);
        end
        total++;
        assert (dut.btn_cnt_q[0] === 2'd0) else begin
            bad++;
            $error("FAIL glitch_cnt: observed=%0d expected=0", dut.btn_cnt_q[0]);
        end

        // 5. Switch change restarts when another bit moves before acceptance.
        switch_raw = 16'h00A5;
        tick();
        tick();
        switch_raw = 16'h00A7;
        for (int e = 2; e < 8; e++) begin
            tick();
            expect_all("sw_restart_wait", 0, 1, 0, 0, 0, 16'h0000);
        end
        tick();
        expect_all("sw_accept", 0, 1, 0, 0, 1, 16'h00A7);
        for (int e = 0; e < 3; e++) begin
            tick();
            expect_all("sw_hold", 0, 1, 0, 0, 0, 16'h00A7);
        end

        // 6. Reset in the middle of a right-button debounce.
        buttonR_raw = 1'b0;
        switch_raw  = 16'h0000;
        for (int e = 0; e < 10; e++) begin
            tick();
        end
        expect_all("pre_rst_settled", 0, 0, 0, 0, 0, 16'h0000);
        buttonR_raw = 1'b1;
        for (int e = 0; e < 3; e++) begin
            tick();
            expect_all("mid_rst_count", 0, 0, 0, 0, 0, 16'h0000);
        end
        rst = 1'b1;
        tick();
        expect_all("mid_rst_applied", 0, 0, 0, 0, 0, 16'h0000);
        rst = 1'b0;
        for (int e = 0; e < 6; e++) begin
            tick();
            expect_all("mid_rst_latency", 0, 0, 0, 0, 0, 16'h0000);
        end
        tick();
        expect_all("mid_rst_accept", 0, 1, 0, 1, 0, 16'h0000);
        tick();
        expect_all("mid_rst_pulse_end", 0, 1, 0, 0, 0, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_input_conditioner.md
# io_input_conditioner

Conditions the raw board inputs (two push buttons, 16 slide switches) before they reach the memory-mapped IO decoder and its IO port. Each input is synchronised into the CPU clock domain, debounced, and delivered as a clean level. Buttons also produce a one-cycle rising-edge pulse. The switch bank produces a one-cycle change pulse. Outputs connect directly to the decoder's `buttonL`, `buttonR` and `switch` inputs.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive cycles a new value must hold before it is accepted (10 ms at 100 MHz); legal range ≥ 2.
- `CNT_WIDTH`, default `$clog2(DEBOUNCE_CYCLES)`: width of each debounce counter.

Ports:
- `clk` in 1: the single system clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `buttonL_raw` in 1: raw, asynchronous left button.
- `buttonR_raw` in 1: raw, asynchronous right button.
- `switch_raw` in 16: raw, asynchronous switch bank.
- `buttonL` out 1: debounced left button level.
- `buttonR` out 1: debounced right button level.
- `buttonL_pulse` out 1: one-cycle pulse on each debounced 0→1 of `buttonL`.
- `buttonR_pulse` out 1: one-cycle pulse on each debounced 0→1 of `buttonR`.
- `switch` out 16: debounced switch vector.
- `switch_changed` out 1: one-cycle pulse when `switch` takes a new value.

## Operation
- Synchroniser: every raw bit passes through two flops (`s1`→`s2`). No logic touches `s1`.
- Button channel (L and R are identical and independent). State per channel: `stable`, `cnt`.
  - `s2 == stable`: `cnt <= 0`.
  - `s2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2`, `cnt <= 0`.
  - Otherwise: `cnt <= cnt + 1`.
  - Any return of `s2` to `stable` before acceptance discards the count.
- Button pulse:
  - `pulse` is registered. It is 1 in exactly the cycle in which `stable` first reads 1 after being 0, and 0 otherwise.
  - There is no pulse on a 1→0 transition.
- Switch channel: a single shared debouncer for the whole vector. State: `sw_stable[15:0]`, `cand[15:0]`, `sw_cnt`.
  - `s2 == sw_stable`: `sw_cnt <= 0`.
  - Else if `s2 != cand`: `cand <= s2`, `sw_cnt <= 0` (restart on any further bit change).
  - Else if `sw_cnt == DEBOUNCE_CYCLES-1`: `sw_stable <= cand`, `sw_cnt <= 0`.
  - Else: `sw_cnt <= sw_cnt + 1`.
  - `switch_changed` is registered. It is 1 in exactly the first cycle `switch` shows a new value.
- Outputs: `buttonL`/`buttonR` = channel `stable`; `switch` = `sw_stable`.
- Counters never exceed `DEBOUNCE_CYCLES-1`, so no wrap occurs.

## Timing
- Reset: every synchroniser flop, `stable`, `sw_stable`, `cand`, every counter and every pulse register is 0. All outputs therefore read 0 in the cycle after `rst` is sampled high.
- Reset mid-debounce: any partial count is discarded. Raw inputs already high at reset release are accepted as 0→1 events after the normal latency, and do produce pulses.
- Latency: take edge 0 as the first edge that samples a new raw value. If that value holds, the output shows it after edge `DEBOUNCE_CYCLES+2`.
- Pulse timing: the pulse coincides with the first cycle of the new level and lasts exactly one cycle.
- Glitch rejection: a raw excursion shorter than `DEBOUNCE_CYCLES` cycles (after synchronisation) produces no output change and no pulse.
- L, R and the switch bank may change on the same edge; each is accepted independently, so simultaneous pulses are legal.
- A level held indefinitely produces exactly one pulse.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.
1. Reset: hold `rst` 2 cycles with all raws at 1 → all outputs 0 during reset. After release, `buttonL`=`buttonR`=1 and `switch`=16'hFFFF at edge 6, each pulse output high for that single cycle.
2. Clean press: `buttonL_raw` 0→1 before edge 0 and held → `buttonL` 1 after edge 6; `buttonL_pulse` high for exactly that one cycle; release gives `buttonL` 0 after six further edges with no pulse.
3. Bounce: `buttonR_raw` toggled 1,0,1,0 on successive cycles, then held at 1 → no output change until 4 consecutive synchronised 1s; exactly one `buttonR_pulse`.
4. Glitch: `buttonL_raw` high for 3 cycles only → `buttonL` stays 0, no pulse, counter back to 0.
5. Switch restart: `switch_raw` = 16'h00A5, then after 2 cycles 16'h00A7, then held → `switch` = 16'h00A7 six edges after the second change; 16'h00A5 never appears; one `switch_changed` pulse.
6. Reset mid-debounce: raise `buttonR_raw`, assert `rst` at edge 3 for 1 cycle, keep raw high → `buttonR` rises 6 edges after reset release, not before.
